// File: rtl/execution_control_unit.sv
// execution_control_unit: run/step/pause sequencer that gates the PC and pipeline latches
// and drains the pipeline once a HALT has been fetched.
module execution_control_unit #(
    parameter int NB_CYCLE   = 32,
    parameter int PIPE_DEPTH = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic                i_halt_detected,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    output logic                o_pc_enable,
    output logic                o_pipe_enable,
    output logic                o_if_flush,
    output logic                o_halted,
    output logic                o_done,
    output logic [1:0]          o_state,
    output logic [NB_CYCLE-1:0] o_cycle_count
);
    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, DONE = 2'b11;
    localparam logic [1:0] CMD_RUN = 2'b01, CMD_STEP = 2'b10, CMD_PAUSE = 2'b11;
    localparam int DW = $clog2(PIPE_DEPTH) + 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_DEPTH - 1);

    logic [1:0]          state, state_nxt;
    logic                halted;
    logic [DW-1:0]       drain_cnt;
    logic [NB_CYCLE-1:0] cycle_count;
    logic                advance, accept, start_halt, drain_end;

    assign advance    = (state == RUN) || (state == STEP);
    assign accept     = i_cmd_valid && o_cmd_ready;
    assign start_halt = advance && !halted && i_halt_detected;
    // Drain ends on the advance cycle that consumes the last outstanding stage.
    assign drain_end  = advance && ((start_halt && PIPE_DEPTH == 1) ||
                                    (halted && drain_cnt == DW'(1)));

    always_comb begin
        state_nxt = drain_end ? DONE :
                    (state == IDLE && accept && i_cmd == CMD_RUN)  ? RUN :
                    (state == IDLE && accept && i_cmd == CMD_STEP) ? STEP :
                    (state == STEP || (state == RUN && accept && i_cmd == CMD_PAUSE)) ? IDLE :
                    state;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            halted      <= 1'b0;
            drain_cnt   <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_nxt;
            if (start_halt) begin
                halted    <= 1'b1;
                drain_cnt <= DRAIN_INIT;
            end else if (advance && halted) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
            if (advance && cycle_count != '1)
                cycle_count <= cycle_count + NB_CYCLE'(1);
        end
    end

    assign o_pipe_enable = advance;
    assign o_pc_enable   = advance && !halted && !i_halt_detected && !i_stall;
    assign o_if_flush    = advance && i_branch_taken && !halted;
    assign o_cmd_ready   = (state == IDLE) || (state == RUN);
    assign o_halted      = halted;
    assign o_done        = state == DONE;
    assign o_state       = state;
    assign o_cycle_count = cycle_count;
endmodule

// File: tb/tb_execution_control_unit.sv
// tb_execution_control_unit: directed vectors, corner-case sequences and random stimulus
// checked against a cycle-level behavioural model of the sequencer.
module tb_execution_control_unit;
    localparam int NB_CYCLE = 32;
    localparam int PIPE_DEPTH = 5;

    logic clk = 1'b0;
    logic i_reset = 1'b0, i_cmd_valid = 1'b0, i_halt_detected = 1'b0, i_stall = 1'b0, i_branch_taken = 1'b0;
    logic [1:0] i_cmd = 2'b00;
    logic o_cmd_ready, o_pc_enable, o_pipe_enable, o_if_flush, o_halted, o_done;
    logic [1:0] o_state;
    logic [NB_CYCLE-1:0] o_cycle_count;

    execution_control_unit #(.NB_CYCLE(NB_CYCLE), .PIPE_DEPTH(PIPE_DEPTH)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready), .i_halt_detected(i_halt_detected), .i_stall(i_stall),
        .i_branch_taken(i_branch_taken), .o_pc_enable(o_pc_enable), .o_pipe_enable(o_pipe_enable),
        .o_if_flush(o_if_flush), .o_halted(o_halted), .o_done(o_done), .o_state(o_state),
        .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: modes as flags, drain as "advances still owed".
    bit m_run, m_step, m_done, m_halt;
    int m_left;
    longint m_cnt;
    localparam longint CNT_MAX = (longint'(1) << NB_CYCLE) - 1;

    function automatic void model_reset();
        m_run = 0; m_step = 0; m_done = 0; m_halt = 0; m_left = 0; m_cnt = 0;
    endfunction

    function automatic void model_update(input bit r, v, input bit [1:0] c, input bit h);
        bit adv, idle, acc, fin, nr;
        if (r) begin
            model_reset();
            return;
        end
        adv  = m_run || m_step;
        idle = !adv && !m_done;
        acc  = v && !m_step && !m_done;
        fin  = 0;
        if (adv) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_halt) m_left--;
            else if (h) begin
                m_halt = 1;
                m_left = PIPE_DEPTH - 1;
            end
            fin = m_halt && m_left == 0;
        end
        nr = m_run;
        m_step = 0;
        if (acc && idle && c == 2'd1) nr = 1;
        if (acc && idle && c == 2'd2) m_step = 1;
        if (acc && m_run && c == 2'd3) nr = 0;
        m_run = nr;
        if (fin) begin
            m_done = 1; m_run = 0; m_step = 0;
        end
    endfunction

    logic s_pc, s_pipe, s_fl, s_rdy, s_h, s_d;
    logic [1:0] s_st;
    longint s_cnt;

    // One clock: drive, sample/compare at negedge, model advances with the edge.
    task automatic cyc(input bit r, v, input bit [1:0] c, input bit h, s, b);
        bit adv;
        i_reset = r; i_cmd_valid = v; i_cmd = c; i_halt_detected = h; i_stall = s; i_branch_taken = b;
        @(negedge clk);
        s_pc = o_pc_enable; s_pipe = o_pipe_enable; s_fl = o_if_flush; s_rdy = o_cmd_ready;
        s_h = o_halted; s_d = o_done; s_st = o_state; s_cnt = longint'(o_cycle_count);
        adv = m_run || m_step;
        chk("m_pc_enable", s_pc, adv && !m_halt && !h && !s);
        chk("m_pipe_enable", s_pipe, adv);
        chk("m_if_flush", s_fl, adv && b && !m_halt);
        chk("m_cmd_ready", s_rdy, !m_step && !m_done);
        chk("m_halted", s_h, m_halt);
        chk("m_done", s_d, m_done);
        chk("m_state", s_st, m_done ? 3 : m_step ? 2 : m_run ? 1 : 0);
        chk("m_cycle_count", s_cnt, m_cnt);
        @(posedge clk);
        model_update(r, v, c, h);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 2'd0, 0, 0, 0);
    endtask

    typedef struct {
        bit v; bit [1:0] c; bit h, s, b;
        bit pc, pipe, fl, rdy, hl, dn; bit [1:0] st; int cnt;
    } vec_t;
    vec_t tv[10];

    initial begin
        // RUN with stall, branch, then a HALT on the third advance and full drain.
        tv[0] = '{1, 2'd1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 2'd0, 0};
        tv[1] = '{0, 2'd0, 0, 1, 0,  0, 1, 0, 1, 0, 0, 2'd1, 0};
        tv[2] = '{0, 2'd0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 2'd1, 1};
        tv[3] = '{0, 2'd0, 1, 0, 0,  0, 1, 0, 1, 0, 0, 2'd1, 2};
        tv[4] = '{0, 2'd0, 1, 0, 0,  0, 1, 0, 1, 1, 0, 2'd1, 3};
        tv[5] = '{0, 2'd0, 0, 0, 1,  0, 1, 0, 1, 1, 0, 2'd1, 4};
        tv[6] = '{0, 2'd0, 0, 0, 0,  0, 1, 0, 1, 1, 0, 2'd1, 5};
        tv[7] = '{0, 2'd0, 0, 0, 0,  0, 1, 0, 1, 1, 0, 2'd1, 6};
        tv[8] = '{0, 2'd0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 2'd3, 7};
        tv[9] = '{1, 2'd1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 2'd3, 7};

        @(posedge clk); #1;
        i_reset = 1;
        @(posedge clk); #1;
        i_reset = 0;
        model_reset();
        @(negedge clk);
        chk("rst_state", o_state, 0);
        chk("rst_halted", o_halted, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ready", o_cmd_ready, 1);
        chk("rst_pc_enable", o_pc_enable, 0);
        chk("rst_pipe_enable", o_pipe_enable, 0);
        chk("rst_if_flush", o_if_flush, 0);
        chk("rst_count", o_cycle_count, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            cyc(0, tv[i].v, tv[i].c, tv[i].h, tv[i].s, tv[i].b);
            chk($sformatf("tv%0d_pc", i), s_pc, tv[i].pc);
            chk($sformatf("tv%0d_pipe", i), s_pipe, tv[i].pipe);
            chk($sformatf("tv%0d_flush", i), s_fl, tv[i].fl);
            chk($sformatf("tv%0d_ready", i), s_rdy, tv[i].rdy);
            chk($sformatf("tv%0d_halted", i), s_h, tv[i].hl);
            chk($sformatf("tv%0d_done", i), s_d, tv[i].dn);
            chk($sformatf("tv%0d_state", i), s_st, tv[i].st);
            chk($sformatf("tv%0d_count", i), s_cnt, tv[i].cnt);
        end

        // Free run: ten advances.
        cyc(1, 0, 2'd0, 0, 0, 0);
        cyc(0, 1, 2'd1, 0, 0, 0);
        repeat (10) idle_cyc();
        cyc(0, 1, 2'd3, 0, 0, 0);
        chk("t1_count", s_cnt, 10);
        chk("t1_state", s_st, 1);
        idle_cyc();
        chk("t1_paused", s_st, 0);

        // Three spaced single steps.
        cyc(1, 0, 2'd0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 2'd2, 0, 0, 0);
            cyc(0, 1, 2'd1, 0, 0, 0);
            chk("t3_step_ready", s_rdy, 0);
            chk("t3_step_pipe", s_pipe, 1);
            idle_cyc();
            chk("t3_after_step_pipe", s_pipe, 0);
        end
        chk("t3_count", s_cnt, 3);
        chk("t3_state", s_st, 0);

        // Pause in mid-drain, then resume to completion.
        cyc(1, 0, 2'd0, 0, 0, 0);
        cyc(0, 1, 2'd1, 0, 0, 0);
        cyc(0, 0, 2'd0, 1, 0, 0);
        idle_cyc();
        cyc(0, 1, 2'd3, 0, 0, 0);
        idle_cyc();
        chk("t5_state", s_st, 0);
        chk("t5_halted", s_h, 1);
        chk("t5_done", s_d, 0);
        cyc(0, 1, 2'd1, 0, 0, 0);
        idle_cyc();
        idle_cyc();
        chk("t5_not_yet_done", s_d, 0);
        idle_cyc();
        chk("t5_done_after", s_d, 1);
        chk("t5_count", s_cnt, 5);

        // Reset during drain.
        cyc(1, 0, 2'd0, 0, 0, 0);
        cyc(0, 1, 2'd1, 0, 0, 0);
        cyc(0, 0, 2'd0, 1, 0, 0);
        idle_cyc();
        cyc(1, 0, 2'd0, 0, 0, 0);
        idle_cyc();
        chk("t6_state", s_st, 0);
        chk("t6_halted", s_h, 0);
        chk("t6_count", s_cnt, 0);
        chk("t6_ready", s_rdy, 1);
        cyc(0, 1, 2'd1, 0, 0, 0);
        idle_cyc();
        chk("t6_restart", s_pipe, 1);

        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
